// File: rtl/video_cntr.sv
`default_nettype none
// ============================================================================
// Module      : video_cntr
// Description : Raster position tracker for a video-out pixel stream.
//               Reports the (x, y) position of the pixel requested in the
//               current cycle. Both counters are plain registers, so overlay
//               logic can index position-dependent data from them
//               combinationally without a path back to the stream inputs.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   H_W       width of h_cntr (pixels per line up to 2^H_W)
//   V_W       width of v_cntr (lines per frame up to 2^V_W)
// Ports
//   clk       in   1    video clock, rising edge
//   reset     in   1    synchronous, active-high reset
//   in_vsync  in   1    frame-start strobe; clears position
//   in_req    in   1    pixel request; one pixel consumed per high cycle
//   in_eol    in   1    last pixel of line (qualified by in_req)
//   in_eof    in   1    last pixel of frame (qualified by in_req)
//   h_cntr    out  H_W  x of the pixel requested this cycle
//   v_cntr    out  V_W  y of the pixel requested this cycle
// Build option
//   VIDEO_CNTR_SAT_EN  when defined, the counters saturate at their all-ones
//                      value instead of wrapping modulo 2^W.
// ============================================================================
module video_cntr #(
  parameter int H_W = 12,
  parameter int V_W = 11
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_vsync,
  input  logic           in_req,
  input  logic           in_eol,
  input  logic           in_eof,
  output logic [H_W-1:0] h_cntr,
  output logic [V_W-1:0] v_cntr
);

  localparam logic [H_W-1:0] C_H_MAX = {H_W{1'b1}};
  localparam logic [V_W-1:0] C_V_MAX = {V_W{1'b1}};
  localparam logic [H_W-1:0] C_H_ONE = {{(H_W-1){1'b0}}, 1'b1};
  localparam logic [V_W-1:0] C_V_ONE = {{(V_W-1){1'b0}}, 1'b1};

  logic [H_W-1:0] h_cntr_q, h_cntr_d;
  logic [V_W-1:0] v_cntr_q, v_cntr_d;
  logic [H_W-1:0] w_h_inc;
  logic [V_W-1:0] w_v_inc;

  // Increment values; the saturating build pins each counter at all-ones.
`ifdef VIDEO_CNTR_SAT_EN
  assign w_h_inc = (h_cntr_q == C_H_MAX) ? C_H_MAX : h_cntr_q + C_H_ONE;
  assign w_v_inc = (v_cntr_q == C_V_MAX) ? C_V_MAX : v_cntr_q + C_V_ONE;
`else
  assign w_h_inc = h_cntr_q + C_H_ONE;
  assign w_v_inc = v_cntr_q + C_V_ONE;
`endif

  // Priority: vsync, then eof, eol and plain pixel (all qualified by in_req).
  // Without in_req the stream is in blanking and eol/eof are ignored.
  always_comb begin
    h_cntr_d = h_cntr_q;
    v_cntr_d = v_cntr_q;
    if (in_vsync) begin
      h_cntr_d = '0;
      v_cntr_d = '0;
    end else if (in_req) begin
      if (in_eof) begin
        h_cntr_d = '0;
        v_cntr_d = '0;
      end else if (in_eol) begin
        h_cntr_d = '0;
        v_cntr_d = w_v_inc;
      end else begin
        h_cntr_d = w_h_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      h_cntr_q <= '0;
      v_cntr_q <= '0;
    end else begin
      h_cntr_q <= h_cntr_d;
      v_cntr_q <= v_cntr_d;
    end
  end

  assign h_cntr = h_cntr_q;
  assign v_cntr = v_cntr_q;

endmodule
`default_nettype wire

// File: tb/tb_video_cntr.sv
`default_nettype none
module tb_video_cntr;

  localparam int H_W = 12;
  localparam int V_W = 11;
  localparam int H_MOD = 1 << H_W;
  localparam int V_MOD = 1 << V_W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_vsync = 1'b0;
  logic in_req = 1'b0;
  logic in_eol = 1'b0;
  logic in_eof = 1'b0;
  logic [H_W-1:0] h_cntr;
  logic [V_W-1:0] v_cntr;

  video_cntr #(.H_W(H_W), .V_W(V_W)) dut (
    .clk(clk), .reset(reset), .in_vsync(in_vsync), .in_req(in_req),
    .in_eol(in_eol), .in_eof(in_eof), .h_cntr(h_cntr), .v_cntr(v_cntr)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  // Reference position: plain integers describing where the next pixel sits.
  int m_x = 0;
  int m_y = 0;

  function automatic int next_pos(input int p, input int modulus);
`ifdef VIDEO_CNTR_SAT_EN
    return (p + 1 > modulus - 1) ? modulus - 1 : p + 1;
`else
    return (p + 1) % modulus;
`endif
  endfunction

  // Effect of one consumed stream event on the raster position.
  function automatic void model_step(input logic rs, input logic vs, input logic rq,
                                     input logic eol, input logic eof);
    if (rs || vs) begin
      m_x = 0; m_y = 0;
    end else if (rq) begin
      if (eof) begin
        m_x = 0; m_y = 0;            // frame done: next pixel is top-left
      end else if (eol) begin
        m_x = 0; m_y = next_pos(m_y, V_MOD);
      end else begin
        m_x = next_pos(m_x, H_MOD);
      end
    end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act != exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  // Drive one cycle of inputs, let the edge happen, then check against model.
  task automatic cyc(input logic rs, input logic vs, input logic rq,
                     input logic eol, input logic eof, input string nm);
    reset = rs; in_vsync = vs; in_req = rq; in_eol = eol; in_eof = eof;
    @(posedge clk);
    model_step(rs, vs, rq, eol, eof);
    #1;
    chk({nm, "_h"}, int'(h_cntr), m_x);
    chk({nm, "_v"}, int'(v_cntr), m_y);
  endtask

  typedef struct {
    logic rs, vs, rq, eol, eof;
    int   eh, ev;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // {reset, vsync, req, eol, eof, expected h, expected v} after the edge
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2, 0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 2};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0, 0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 0};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, 1};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 1};
    tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 0};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0};

    @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].rs, tbl[i].vs, tbl[i].rq, tbl[i].eol, tbl[i].eof, "tbl_model");
      chk($sformatf("tbl%0d_h", i), int'(h_cntr), tbl[i].eh);
      chk($sformatf("tbl%0d_v", i), int'(v_cntr), tbl[i].ev);
    end

    // 1: reset held with random inputs, then hold while idle
    cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "rst_a");
    cyc(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), "rst_b");
    chk("rst_h0", int'(h_cntr), 0);
    chk("rst_v0", int'(v_cntr), 0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rst_hold");

    // 2: two 1280-pixel lines, eof on last pixel of line 1
    for (int ln = 0; ln < 2; ln++) begin
      for (int x = 0; x < 1280; x++) begin
        if (x == 0 || x == 1279) begin
          chk($sformatf("line%0d_x%0d_h", ln, x), int'(h_cntr), x);
          chk($sformatf("line%0d_x%0d_v", ln, x), int'(v_cntr), ln);
        end
        cyc(1'b0, 1'b0, 1'b1, x == 1279, (ln == 1) && (x == 1279), "lines");
      end
    end
    chk("after_eof_h", int'(h_cntr), 0);
    chk("after_eof_v", int'(v_cntr), 0);

    // 3: three idle cycles after every 4th pixel; sequence stays contiguous
    for (int p = 0; p < 20; p++) begin
      chk($sformatf("gap_px%0d", p), int'(h_cntr), p);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "gap_req");
      if (p % 4 == 3)
        for (int g = 0; g < 3; g++) begin
          cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "gap_idle");
          chk("gap_hold", int'(h_cntr), p + 1);
        end
    end

    // 4: vsync beats coincident req&eol at h=500, v=10
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "vs_rst");
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "vs_lines");
    for (int i = 0; i < 500; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "vs_pix");
    chk("vs_pre_h", int'(h_cntr), 500);
    chk("vs_pre_v", int'(v_cntr), 10);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, "vs_evt");
    chk("vs_post_h", int'(h_cntr), 0);
    chk("vs_post_v", int'(v_cntr), 0);

    // 5: eol/eof without req at h=37 are ignored
    for (int i = 0; i < 37; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "ign_pix");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "ign_eol");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "ign_eof");
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "ign_both");
    chk("ign_h37", int'(h_cntr), 37);
    chk("ign_v0", int'(v_cntr), 0);

    // 6a: 4100 pixels with no eol -> wrap to 4 (or hold at 4095)
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "hov_rst");
    for (int i = 0; i < 4100; i++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "hov");
`ifdef VIDEO_CNTR_SAT_EN
      if (i == 4098) chk("hov_4099", int'(h_cntr), 4095);
`else
      if (i == 4095) chk("hov_wrap0", int'(h_cntr), 0);
      if (i == 4098) chk("hov_wrap3", int'(h_cntr), 3);
`endif
    end
`ifdef VIDEO_CNTR_SAT_EN
    chk("hov_final", int'(h_cntr), 4095);
`else
    chk("hov_final", int'(h_cntr), 4);
`endif

    // 6b: 2050 single-pixel lines -> v wraps to 2 (or holds at 2047)
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "vov_rst");
    for (int i = 0; i < 2050; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, "vov");
`ifdef VIDEO_CNTR_SAT_EN
    chk("vov_final", int'(v_cntr), 2047);
`else
    chk("vov_final", int'(v_cntr), 2);
`endif
    chk("vov_h0", int'(h_cntr), 0);

    // Randomized stream against the reference model
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "rnd_rst");
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 99) == 0,
          $urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0,
          $urandom_range(0, 149) == 0, "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
